// File: rtl/video_frame_gen.sv
`default_nettype none
// ============================================================================
// Module   : video_frame_gen
// Purpose  : Composite frame generator for the tape data path. Produces
//            NTSC-style vertical (equalising / serrated) and horizontal sync,
//            plus active lines that carry a start marker, a payload window
//            fed over a valid/ready handshake, and an end marker, all as
//            8-bit (DATA_W) levels for the video DAC.
// Ports    : clkin      - pixel clock
//            rst        - asynchronous active-high reset
//            line_req   - upstream has a line to send (sampled once per line)
//            data_in    - payload word
//            data_valid - data_in valid this cycle
//            ready      - block accepts data_in this cycle
//            video_out  - level to DAC
//            sync       - active-low sync to DAC
//            field      - current field (0/1)
//            underflow  - one-cycle pulse: previous active line missed words
// Options  : VIDEO_FRAME_GEN_CHECKSUM_EN - when defined, the last payload
//            slot carries the modulo-2^DATA_W sum of the preceding payload
//            words of that line and ready is offered one cycle less.
// Revision : 1.0 - initial release
// ============================================================================
module video_frame_gen #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned LINE_PIXELS  = 400,
  parameter int unsigned LINES_F0     = 263,
  parameter int unsigned INTERLACE    = 1,
  parameter int unsigned ACTIVE_FIRST = 19,
  parameter int unsigned HSYNC_W      = 29,
  parameter int unsigned EQ_W         = 13,
  parameter int unsigned BROAD_GAP    = 30,
  parameter int unsigned MARK_PIX     = 57,
  parameter int unsigned DATA_LEN     = 331,
  parameter int unsigned BLANK_LEVEL  = 41,
  parameter int unsigned START_ON     = 180,
  parameter int unsigned START_OFF    = 42,
  parameter int unsigned END_ON       = 200,
  parameter int unsigned END_OFF      = 49
) (
  input  logic              clkin,
  input  logic              rst,
  input  logic              line_req,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              ready,
  output logic [DATA_W-1:0] video_out,
  output logic              sync,
  output logic              field,
  output logic              underflow
);

  localparam int unsigned HALF        = LINE_PIXELS / 2;
  localparam int unsigned PIX_W       = $clog2(LINE_PIXELS);
  localparam int unsigned LINE_W      = $clog2(LINES_F0 + 2);
  localparam int unsigned ACTIVE_LAST = ACTIVE_FIRST + 242;
`ifdef VIDEO_FRAME_GEN_CHECKSUM_EN
  localparam int unsigned PAY_SLOTS   = DATA_LEN - 1;
`else
  localparam int unsigned PAY_SLOTS   = DATA_LEN;
`endif

  localparam logic [DATA_W-1:0] BLANK_L     = DATA_W'(BLANK_LEVEL);
  localparam logic [DATA_W-1:0] START_ON_L  = DATA_W'(START_ON);
  localparam logic [DATA_W-1:0] START_OFF_L = DATA_W'(START_OFF);
  localparam logic [DATA_W-1:0] END_ON_L    = DATA_W'(END_ON);
  localparam logic [DATA_W-1:0] END_OFF_L   = DATA_W'(END_OFF);

  // Raster position of the pixel being computed; outputs lag it by one cycle.
  logic [PIX_W-1:0]  pix;
  logic [LINE_W-1:0] line_cnt;
  logic              fld;
  logic              ctl;
  logic              miss;

  logic [31:0] px;
  logic [31:0] ln;
  logic [31:0] hp;
  logic        second_half;
  logic        eq_low;
  logic        broad_low;
  logic        low;
  logic        active;
  logic        line_last;
  logic        field_last;

  logic [DATA_W-1:0] video_d;
  logic              ready_d;
  logic              miss_set;
`ifdef VIDEO_FRAME_GEN_CHECKSUM_EN
  logic [DATA_W-1:0] csum;
  logic [DATA_W-1:0] csum_d;
`endif

  assign px          = 32'(pix);
  assign ln          = 32'(line_cnt);
  assign second_half = (px >= HALF);
  // Position within the current half-line; vertical-interval pulses repeat
  // identically in both halves.
  assign hp          = second_half ? (px - HALF) : px;
  assign eq_low      = (hp < EQ_W);
  assign broad_low   = (hp < (HALF - BROAD_GAP));
  assign line_last   = (px == (LINE_PIXELS - 1));
  // Field 1 is one line longer than field 0 (fld is always 0 without interlace).
  assign field_last  = (ln == (LINES_F0 - 1 + 32'(fld)));
  assign active      = (ln >= ACTIVE_FIRST) && (ln <= ACTIVE_LAST);

  // Sync shape per line type. In field 1 lines 2 and 5 switch pulse type at
  // mid-line, giving the half-line offset between fields.
  always_comb begin
    low = (px < HSYNC_W);
    if (ln == 32'd3 || ln == 32'd4) begin
      low = broad_low;
    end else if (ln == 32'd2) begin
      low = (fld && second_half) ? broad_low : eq_low;
    end else if (ln == 32'd5) begin
      low = (fld && second_half) ? eq_low : broad_low;
    end else if (ln <= 32'd8) begin
      low = eq_low;
    end
  end

  // Level and handshake for the pixel at the counter position.
  always_comb begin
    video_d  = low ? '0 : BLANK_L;
    miss_set = 1'b0;
    // ready leads each payload slot by one cycle, independent of ctl.
    ready_d  = active && (px >= MARK_PIX) && (px < (MARK_PIX + PAY_SLOTS));
`ifdef VIDEO_FRAME_GEN_CHECKSUM_EN
    csum_d   = (px == 32'd0) ? '0 : csum;
`endif
    if (active && !low) begin
      if (px == MARK_PIX) begin
        video_d = ctl ? START_ON_L : START_OFF_L;
      end else if ((px > MARK_PIX) && (px <= (MARK_PIX + PAY_SLOTS))) begin
        // The raster never waits: a missing word becomes blanking.
        if (ready && data_valid) begin
          video_d = data_in;
        end else if (ready) begin
          miss_set = 1'b1;
        end
`ifdef VIDEO_FRAME_GEN_CHECKSUM_EN
        csum_d = csum + video_d;
`endif
      end
`ifdef VIDEO_FRAME_GEN_CHECKSUM_EN
      else if (px == (MARK_PIX + DATA_LEN)) begin
        video_d = csum;
      end
`endif
      else if (px == (MARK_PIX + DATA_LEN + 1)) begin
        video_d = ctl ? END_ON_L : END_OFF_L;
      end
    end
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      pix       <= '0;
      line_cnt  <= '0;
      fld       <= 1'b0;
      ctl       <= 1'b0;
      miss      <= 1'b0;
      video_out <= BLANK_L;
      sync      <= 1'b1;
      ready     <= 1'b0;
      field     <= 1'b0;
      underflow <= 1'b0;
`ifdef VIDEO_FRAME_GEN_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      video_out <= video_d;
      sync      <= ~low;
      ready     <= ready_d;
      field     <= fld;
      // The miss flag of the line just finished is reported at pixel 0.
      underflow <= (px == 32'd0) && miss;
      if (px == 32'd0) begin
        miss <= 1'b0;
      end else if (miss_set) begin
        miss <= 1'b1;
      end
      if (line_last) begin
        ctl <= line_req;
      end
`ifdef VIDEO_FRAME_GEN_CHECKSUM_EN
      csum <= csum_d;
`endif
      if (line_last) begin
        pix <= '0;
        if (field_last) begin
          line_cnt <= '0;
          if (INTERLACE != 0) begin
            fld <= ~fld;
          end
        end else begin
          line_cnt <= line_cnt + LINE_W'(1);
        end
      end else begin
        pix <= pix + PIX_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_video_frame_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_frame_gen
// Purpose  : Self-checking bench for video_frame_gen. A stimulus process
//            drives randomized payload traffic and line requests and pushes
//            the expected output of every pixel into a queue, derived from
//            the raster rules (sync intervals, markers, payload window,
//            underflow). A monitor pops and compares each output cycle.
//            Geometry uses a shortened field so that two fields plus a
//            mid-line asynchronous reset fit in a short run.
// Options  : VIDEO_FRAME_GEN_CHECKSUM_EN - expects the checksum slot.
// Revision : 1.0 - initial release
// ============================================================================
module tb_video_frame_gen;

  localparam int LP    = 400;
  localparam int LF0   = 30;
  localparam int INTL  = 1;
  localparam int AF    = 19;
  localparam int HS    = 29;
  localparam int EQ    = 13;
  localparam int GAP   = 30;
  localparam int MARK  = 57;
  localparam int DLEN  = 331;
  localparam int BLANK = 41;
  localparam int SON   = 180;
  localparam int SOFF  = 42;
  localparam int EON   = 200;
  localparam int EOFF  = 49;
  localparam int H     = LP / 2;
`ifdef VIDEO_FRAME_GEN_CHECKSUM_EN
  localparam int NPAY  = DLEN - 1;
`else
  localparam int NPAY  = DLEN;
`endif

  logic       clkin = 1'b0;
  logic       rst = 1'b0;
  logic       line_req = 1'b0;
  logic [7:0] data_in = 8'd0;
  logic       data_valid = 1'b0;
  logic       ready;
  logic [7:0] video_out;
  logic       sync;
  logic       field;
  logic       underflow;

  video_frame_gen #(
    .DATA_W(8), .LINE_PIXELS(LP), .LINES_F0(LF0), .INTERLACE(INTL),
    .ACTIVE_FIRST(AF), .HSYNC_W(HS), .EQ_W(EQ), .BROAD_GAP(GAP),
    .MARK_PIX(MARK), .DATA_LEN(DLEN), .BLANK_LEVEL(BLANK),
    .START_ON(SON), .START_OFF(SOFF), .END_ON(EON), .END_OFF(EOFF)
  ) dut (
    .clkin(clkin), .rst(rst), .line_req(line_req), .data_in(data_in),
    .data_valid(data_valid), .ready(ready), .video_out(video_out),
    .sync(sync), .field(field), .underflow(underflow)
  );

  always #5 clkin = ~clkin;

  typedef struct {
    int video;
    bit sync;
    bit rdy;
    bit fld;
    bit uf;
    int pix;
    int ln;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   checking = 1'b0;
  int   ctx_f = -1, ctx_l = -1, ctx_p = -1;

  // Reference state: position of the next pixel to be output.
  int mp, ml, mf;
  bit mctl, mmiss;
  int msum, mode, ramp, drop_at;
  int rdy_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s (f%0d l%0d p%0d) t=%0t: got %0d, want %0d",
               name, ctx_f, ctx_l, ctx_p, $time, act, exp);
    end
  endtask

  function automatic bit sync_low(input int p, input int l, input int f);
    bit eq, br;
    eq = (p < EQ) || (p >= H && p < H + EQ);
    br = (p < H - GAP) || (p >= H && p < 2 * H - GAP);
    if (l == 3 || l == 4) return br;
    if (l == 2) return f != 0 ? ((p < EQ) || (p >= H && p < 2 * H - GAP)) : eq;
    if (l == 5) return f != 0 ? ((p < H - GAP) || (p >= H && p < H + EQ)) : br;
    if (l <= 8) return eq;
    return p < HS;
  endfunction

  function automatic bit is_active(input int l);
    return (l >= AF) && (l <= AF + 242);
  endfunction

  function automatic bit is_slot(input int p);
    return (p >= MARK + 1) && (p <= MARK + NPAY);
  endfunction

  task automatic model_reset();
    mp = 0; ml = 0; mf = 0; mctl = 1'b0; mmiss = 1'b0; msum = 0;
  endtask

  // Called at a falling edge: drive inputs for the next rising edge and
  // queue the output expected after it.
  task automatic step();
    exp_t e;
    bit   dv;
    int   din;
    bit   low;
    if (mp == 0) begin
      mode    = $urandom_range(0, 2);
      ramp    = 0;
      drop_at = MARK + 1 + $urandom_range(0, NPAY - 3);
    end
    if (mp == 100) line_req = 1'($urandom_range(0, 1));
    case (mode)
      0: begin
        dv  = ($urandom_range(0, 31) != 0);
        din = $urandom_range(0, 255);
      end
      default: begin
        dv  = !(mode == 2 && mp >= drop_at && mp < drop_at + 3);
        din = ramp % 256;
      end
    endcase
    data_valid = dv;
    data_in    = din[7:0];

    low   = sync_low(mp, ml, mf);
    e.sync = !low;
    e.fld  = (mf != 0);
    e.pix  = mp;
    e.ln   = ml;
    e.rdy  = is_active(ml) && is_slot(mp + 1);
    e.uf   = (mp == 0) && mmiss;
    if (mp == 0) begin
      mmiss = 1'b0;
      msum  = 0;
    end
    e.video = low ? 0 : BLANK;
    if (!low && is_active(ml)) begin
      if (mp == MARK) begin
        e.video = mctl ? SON : SOFF;
      end else if (is_slot(mp)) begin
        e.video = dv ? din : BLANK;
        if (!dv) mmiss = 1'b1;
        else ramp++;
        msum = (msum + e.video) % 256;
      end
`ifdef VIDEO_FRAME_GEN_CHECKSUM_EN
      else if (mp == MARK + DLEN) begin
        e.video = msum;
      end
`endif
      else if (mp == MARK + DLEN + 1) begin
        e.video = mctl ? EON : EOFF;
      end
    end
    q.push_back(e);

    if (mp == LP - 1) mctl = line_req;
    mp++;
    if (mp == LP) begin
      mp = 0;
      ml++;
      if (ml == LF0 + mf) begin
        ml = 0;
        mf = (INTL != 0) ? 1 - mf : 0;
      end
    end
  endtask

  exp_t me;
  always @(posedge clkin) begin
    #1;
    if (checking) begin
      if (q.size() == 0) begin
        chk("queue_underrun", 0, 1);
      end else begin
        me = q.pop_front();
        ctx_f = me.fld; ctx_l = me.ln; ctx_p = me.pix;
        chk("video_out", int'(video_out), me.video);
        chk("sync", int'(sync), int'(me.sync));
        chk("ready", int'(ready), int'(me.rdy));
        chk("field", int'(field), int'(me.fld));
        chk("underflow", int'(underflow), int'(me.uf));
        if (me.pix == 0) rdy_cnt = 0;
        if (ready) rdy_cnt++;
        if (me.pix == LP - 1 && is_active(me.ln))
          chk("ready_cycles_per_line", rdy_cnt, NPAY);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    ctx_f = -1; ctx_l = -1; ctx_p = -1;
    chk({tag, "_sync"}, int'(sync), 1);
    chk({tag, "_video"}, int'(video_out), BLANK);
    chk({tag, "_ready"}, int'(ready), 0);
    chk({tag, "_underflow"}, int'(underflow), 0);
    chk({tag, "_field"}, int'(field), 0);
  endtask

  initial begin
    model_reset();
    mode = 0; ramp = 0; drop_at = MARK + 1;
    #1 rst = 1'b1;
    repeat (2) @(negedge clkin);
    check_reset_outputs("reset");

    // Release and free-run one full frame plus part of the next field 0,
    // stopping just after pixel 200 of active line 20 has been output.
    rst = 1'b0;
    checking = 1'b1;
    for (int i = 0; i < (2 * LF0 + 1 + 20) * LP + 201; i++) begin
      step();
      @(negedge clkin);
    end

    // Asynchronous reset in the middle of the payload window.
    checking = 1'b0;
    q.delete();
    ctx_f = -1; ctx_l = -1; ctx_p = -1;
    chk("ready_before_reset", int'(ready), 1);
    #1 rst = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    repeat (3) @(negedge clkin);

    rst = 1'b0;
    model_reset();
    checking = 1'b1;
    for (int i = 0; i < 22 * LP; i++) begin
      step();
      @(negedge clkin);
    end
    checking = 1'b0;
    ctx_f = -1; ctx_l = -1; ctx_p = -1;
    chk("queue_drain", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
